pose_error_generator: RTL

//  Closes the motion loop around the error controller. Latches a target pose and dead-reckons the pose by

---
 rtl/pose_error_generator_pkg.sv | 34 +++
 rtl/pose_axis_integrator.sv | 83 ++++++++
 rtl/pose_error_generator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pose_error_generator_pkg.sv
// Shared number format, FSM encoding and sign-magnitude <-> two's complement helpers
// for the pose error generator and its per-axis integrators.
package pose_error_generator_pkg;

    localparam int N_WIDTH   = 17;
    localparam int FRAC_BITS = 8;
    localparam int MAG_W     = N_WIDTH - 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pose_state_e;

    // Negative zero collapses to 0 because -0 == 0 in two's complement.
    function automatic logic signed [N_WIDTH-1:0] sm2tc(input logic [N_WIDTH-1:0] sm);
        logic signed [N_WIDTH-1:0] mag;
        mag = $signed({1'b0, sm[MAG_W-1:0]});
        return sm[N_WIDTH-1] ? -mag : mag;
    endfunction

    // Takes one guard bit of headroom; magnitudes beyond 16 bits clamp to all ones.
    function automatic logic [N_WIDTH-1:0] tc2sm(input logic signed [N_WIDTH:0] v);
        logic [N_WIDTH:0] mag;
        logic [MAG_W-1:0] magSat;
        mag = v[N_WIDTH] ? $unsigned(-v) : $unsigned(v);
        if (mag > {2'b00, {MAG_W{1'b1}}}) begin
            magSat = '1;
        end else begin
            magSat = mag[MAG_W-1:0];
        end
        return {v[N_WIDTH], magSat};
    endfunction

endpackage

// File: rtl/pose_axis_integrator.sv
// One axis of dead reckoning: saturating velocity accumulator, latched target,
// and registered sign-magnitude pose and error outputs.
module pose_axis_integrator
    import pose_error_generator_pkg::*;
#(
    parameter int DT_SHIFT   = 8,
    parameter bit NEGATE_VEL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic               tick_i,
    input  logic [N_WIDTH-1:0] target_i,
    input  logic [N_WIDTH-1:0] vel_i,
    output logic [N_WIDTH-1:0] err_o,
    output logic [N_WIDTH-1:0] pose_o,
    output logic [MAG_W-1:0]   errMag_o
);

    localparam int ACC_W = N_WIDTH + DT_SHIFT;
    localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SUM_MIN = -SUM_MAX;

    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [N_WIDTH-1:0] targetTc_q, targetTc_d;
    logic [N_WIDTH-1:0]        err_q, err_d;
    logic [N_WIDTH-1:0]        pose_q, pose_d;

    logic signed [N_WIDTH-1:0] velTc;
    logic signed [N_WIDTH-1:0] velStep;
    logic signed [N_WIDTH-1:0] poseTop;
    logic signed [ACC_W:0]     accSum;
    logic signed [N_WIDTH:0]   errTc;

    // Adding the raw Q8.8 velocity into a Q.8+DT_SHIFT accumulator is exactly v*dt.
    always_comb begin
        velTc   = sm2tc(vel_i);
        velStep = NEGATE_VEL ? -velTc : velTc;
        accSum  = $signed({acc_q[ACC_W-1], acc_q})
                + $signed({{(DT_SHIFT+1){velStep[N_WIDTH-1]}}, velStep});

        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (tick_i) begin
            if (accSum > SUM_MAX) begin
                acc_d = SUM_MAX[ACC_W-1:0];
            end else if (accSum < SUM_MIN) begin
                acc_d = SUM_MIN[ACC_W-1:0];
            end else begin
                acc_d = accSum[ACC_W-1:0];
            end
        end

        targetTc_d = load_i ? sm2tc(target_i) : targetTc_q;

        poseTop = acc_q[ACC_W-1 -: N_WIDTH];
        errTc   = $signed({targetTc_q[N_WIDTH-1], targetTc_q})
                - $signed({poseTop[N_WIDTH-1], poseTop});
        err_d   = tc2sm(errTc);
        pose_d  = tc2sm($signed({poseTop[N_WIDTH-1], poseTop}));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            targetTc_q <= '0;
            err_q      <= '0;
            pose_q     <= '0;
        end else begin
            acc_q      <= acc_d;
            targetTc_q <= targetTc_d;
            err_q      <= err_d;
            pose_q     <= pose_d;
        end
    end

    assign err_o    = err_q;
    assign pose_o   = pose_q;
    assign errMag_o = err_d[MAG_W-1:0];

endmodule

// File: rtl/pose_error_generator.sv
// Closes the motion loop: latches a target, dead-reckons pose from velocity commands,
// feeds target-minus-pose back as controller error and pulses DONE once settled.
module pose_error_generator
    import pose_error_generator_pkg::*;
#(
    parameter int                 TICK_CYCLES  = 195312,
    parameter int                 DT_SHIFT     = 8,
    parameter logic [N_WIDTH-1:0] H_XY         = 17'h0001A,
    parameter logic [N_WIDTH-1:0] H_Z          = 17'h00A00,
    parameter int                 SETTLE_TICKS = 16
) (
    input  logic               POSE_ERR_CLOCK_50,
    input  logic               POSE_ERR_RESET_InHigh,
    input  logic               POSE_ERR_START_In,
    input  logic               POSE_ERR_ABORT_In,
    input  logic               POSE_ERR_ZERO_POSE_In,
    input  logic [N_WIDTH-1:0] POSE_ERR_TARGET_X_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERR_TARGET_Y_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERR_TARGET_Z_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERR_VX_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERR_VY_InBus,
    input  logic [N_WIDTH-1:0] POSE_ERR_WZ_InBus,
    output logic [N_WIDTH-1:0] POSE_ERR_X_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERR_Y_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERR_Z_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERR_POSE_X_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERR_POSE_Y_OutBus,
    output logic [N_WIDTH-1:0] POSE_ERR_POSE_Z_OutBus,
    output logic               POSE_ERR_BUSY_Out,
    output logic               POSE_ERR_DONE_Out
);

    localparam int TICK_W   = $clog2(TICK_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);
    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_CYCLES - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

    pose_state_e         state_q, state_d;
    logic [TICK_W-1:0]   tickCnt_q, tickCnt_d;
    logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
    logic                tickPending_q, tickPending_d;
    logic                done_q, done_d;

    logic                tick;
    logic                loadTarget;
    logic                zeroPose;
    logic                allInBand;
    logic [MAG_W-1:0]    errMagX, errMagY, errMagZ;

    assign allInBand = (errMagX <= H_XY[MAG_W-1:0])
                    && (errMagY <= H_XY[MAG_W-1:0])
                    && (errMagZ <= H_Z[MAG_W-1:0]);

    // Settling is judged one clock after each tick, when the errors reflect the new pose.
    always_comb begin
        state_d       = state_q;
        tickCnt_d     = tickCnt_q;
        settleCnt_d   = settleCnt_q;
        done_d        = 1'b0;
        tick          = 1'b0;
        loadTarget    = 1'b0;
        zeroPose      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                zeroPose = POSE_ERR_ZERO_POSE_In;
                if (POSE_ERR_START_In && !POSE_ERR_ABORT_In) begin
                    state_d     = ST_RUN;
                    tickCnt_d   = '0;
                    settleCnt_d = '0;
                    loadTarget  = 1'b1;
                end
            end
            ST_RUN: begin
                if (POSE_ERR_ABORT_In) begin
                    state_d     = ST_IDLE;
                    settleCnt_d = '0;
                end else if (POSE_ERR_START_In) begin
                    loadTarget  = 1'b1;
                    settleCnt_d = '0;
                end else if (tickPending_q) begin
                    if (!allInBand) begin
                        settleCnt_d = '0;
                    end else if (settleCnt_q == SETTLE_LAST) begin
                        state_d     = ST_IDLE;
                        settleCnt_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        settleCnt_d = settleCnt_q + 1'b1;
                    end
                end
                // Leaving RUN freezes the pose, so no tick on the exit cycle.
                if (state_d == ST_RUN) begin
                    tick      = (tickCnt_q == TICK_LAST);
                    tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tickPending_d = tick;
    end

    always_ff @(posedge POSE_ERR_CLOCK_50) begin
        if (POSE_ERR_RESET_InHigh) begin
            state_q       <= ST_IDLE;
            tickCnt_q     <= '0;
            settleCnt_q   <= '0;
            tickPending_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tickCnt_q     <= tickCnt_d;
            settleCnt_q   <= settleCnt_d;
            tickPending_q <= tickPending_d;
            done_q        <= done_d;
        end
    end

    assign POSE_ERR_BUSY_Out = (state_q == ST_RUN);
    assign POSE_ERR_DONE_Out = done_q;

    // No heading rotation: X follows -VY, Y follows VX, Z follows WZ.
    pose_axis_integrator #(.DT_SHIFT(DT_SHIFT), .NEGATE_VEL(1'b1)) uAxisX (
        .clk_i    (POSE_ERR_CLOCK_50),
        .rst_i    (POSE_ERR_RESET_InHigh),
        .load_i   (loadTarget),
        .clear_i  (zeroPose),
        .tick_i   (tick),
        .target_i (POSE_ERR_TARGET_X_InBus),
        .vel_i    (POSE_ERR_VY_InBus),
        .err_o    (POSE_ERR_X_OutBus),
        .pose_o   (POSE_ERR_POSE_X_OutBus),
        .errMag_o (errMagX)
    );

    pose_axis_integrator #(.DT_SHIFT(DT_SHIFT), .NEGATE_VEL(1'b0)) uAxisY (
        .clk_i    (POSE_ERR_CLOCK_50),
        .rst_i    (POSE_ERR_RESET_InHigh),
        .load_i   (loadTarget),
        .clear_i  (zeroPose),
        .tick_i   (tick),
        .target_i (POSE_ERR_TARGET_Y_InBus),
        .vel_i    (POSE_ERR_VX_InBus),
        .err_o    (POSE_ERR_Y_OutBus),
        .pose_o   (POSE_ERR_POSE_Y_OutBus),
        .errMag_o (errMagY)
    );

    pose_axis_integrator #(.DT_SHIFT(DT_SHIFT), .NEGATE_VEL(1'b0)) uAxisZ (
        .clk_i    (POSE_ERR_CLOCK_50),
        .rst_i    (POSE_ERR_RESET_InHigh),
        .load_i   (loadTarget),
        .clear_i  (zeroPose),
        .tick_i   (tick),
        .target_i (POSE_ERR_TARGET_Z_InBus),
        .vel_i    (POSE_ERR_WZ_InBus),
        .err_o    (POSE_ERR_Z_OutBus),
        .pose_o   (POSE_ERR_POSE_Z_OutBus),
        .errMag_o (errMagZ)
    );

endmodule
